// File: rtl/fpga_cfg_loader.sv
// rtl/fpga_cfg_loader.sv - configuration-chain loader that serialises host words onto the fabric ccff chain
//
// Purpose:
//   Accepts bitstream words over a valid/ready stream and shifts them MSB-first
//   into the fabric configuration chain. Generates a registered prog_clk.
//   Holds fabric_reset high while programming, and releases it once exactly
//   CHAIN_LEN bits have been clocked in.
//
// Parameters:
//   CHAIN_LEN - number of configuration flops in the chain (>= 1)
//   DATA_W    - host word width (1..32)
//   PROG_DIV  - clk cycles per prog_clk half-period (>= 1)
//   TIMEOUT   - max clk cycles waiting for a word before error (0 = disabled)
//
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   start                 - session start pulse (honoured in IDLE/DONE/ERROR)
//   s_data/s_valid/s_ready- bitstream word handshake
//   ccff_head, prog_clk   - serial data and programming clock to the fabric
//   ccff_tail             - chain output from the fabric (readback only)
//   fabric_reset          - active-high fabric reset
//   busy, done, error     - session status
//   bit_count             - bits clocked into the chain this session
//   readback_crc          - CRC-8 of ccff_tail (only with FPGA_CFG_LOADER_READBACK_EN)
//
// Optional feature macro: FPGA_CFG_LOADER_READBACK_EN

module fpga_cfg_loader #(
  parameter int  CHAIN_LEN = 1024,
  parameter int  DATA_W    = 8,
  parameter int  PROG_DIV  = 1,
  parameter int  TIMEOUT   = 65535,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              prog_clk,
  input  logic              ccff_tail,
  output logic              fabric_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
`ifdef FPGA_CFG_LOADER_READBACK_EN
  output logic [7:0]        readback_crc,
`endif
  output logic [CNT_W-1:0]  bit_count
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int DIV_W = (PROG_DIV > 1) ? $clog2(PROG_DIV) : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
  localparam logic [IDX_W-1:0] IDX_TOP     = IDX_W'(DATA_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(PROG_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST     = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_WORD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_DONE,
    ST_ERROR
  } state_e;

  state_e             state_q;
  logic [DATA_W-1:0]  shreg_q;
  logic [IDX_W-1:0]   bit_idx_q;
  logic [DIV_W-1:0]   div_cnt_q;
  logic [TO_W-1:0]    to_cnt_q;
  logic [CNT_W-1:0]   bit_count_q;
  logic               s_ready_q;
  logic               ccff_head_q;
  logic               prog_clk_q;
  logic               fabric_reset_q;
  logic               busy_q;
  logic               done_q;
  logic               error_q;

  // Index of the next bit to present once the current one has been clocked.
  logic [IDX_W-1:0]   bit_idx_d;
  assign bit_idx_d = bit_idx_q - 1'b1;

`ifdef FPGA_CFG_LOADER_READBACK_EN
  // CRC-8, polynomial x^8 + x^2 + x + 1; ccff_tail enters as the feedback bit.
  logic [7:0] crc_q;
  logic [7:0] crc_d;
  logic       crc_fb;
  assign crc_fb       = crc_q[7] ^ ccff_tail;
  assign crc_d        = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
  assign readback_crc = crc_q;
`else
  logic unused_ccff_tail;
  assign unused_ccff_tail = ccff_tail;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      shreg_q        <= '0;
      bit_idx_q      <= '0;
      div_cnt_q      <= '0;
      to_cnt_q       <= '0;
      bit_count_q    <= '0;
      s_ready_q      <= 1'b0;
      ccff_head_q    <= 1'b0;
      prog_clk_q     <= 1'b0;
      fabric_reset_q <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
`ifdef FPGA_CFG_LOADER_READBACK_EN
      crc_q          <= 8'h00;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          // s_ready is still 0 here, so a word offered alongside start is
          // not taken; acceptance begins in WAIT_WORD.
          if (start) begin
            state_q        <= ST_WAIT_WORD;
            s_ready_q      <= 1'b1;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            fabric_reset_q <= 1'b1;
            prog_clk_q     <= 1'b0;
            bit_count_q    <= '0;
            to_cnt_q       <= '0;
            div_cnt_q      <= '0;
`ifdef FPGA_CFG_LOADER_READBACK_EN
            crc_q          <= 8'h00;
`endif
          end
        end

        ST_WAIT_WORD: begin
          if (s_valid) begin
            state_q     <= ST_SHIFT_LO;
            s_ready_q   <= 1'b0;
            shreg_q     <= s_data;
            bit_idx_q   <= IDX_TOP;
            ccff_head_q <= s_data[DATA_W-1];
            div_cnt_q   <= '0;
            to_cnt_q    <= '0;
          end else if (TIMEOUT != 0) begin
            if (to_cnt_q == TO_LAST) begin
              state_q   <= ST_ERROR;
              s_ready_q <= 1'b0;
              error_q   <= 1'b1;
              busy_q    <= 1'b0;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
        end

        ST_SHIFT_LO: begin
          if (div_cnt_q == DIV_LAST) begin
            state_q     <= ST_SHIFT_HI;
            prog_clk_q  <= 1'b1;
            bit_count_q <= bit_count_q + 1'b1;
            div_cnt_q   <= '0;
`ifdef FPGA_CFG_LOADER_READBACK_EN
            // Sampled on the same edge that raises prog_clk.
            crc_q       <= crc_d;
`endif
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end

        ST_SHIFT_HI: begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_q  <= '0;
            prog_clk_q <= 1'b0;
            if (bit_count_q == CHAIN_LEN_C) begin
              // Chain full: unused low-order bits of this word are dropped.
              state_q        <= ST_DONE;
              fabric_reset_q <= 1'b0;
              done_q         <= 1'b1;
              busy_q         <= 1'b0;
            end else if (bit_idx_q == '0) begin
              state_q   <= ST_WAIT_WORD;
              s_ready_q <= 1'b1;
              to_cnt_q  <= '0;
            end else begin
              // ccff_head only moves here, i.e. at the start of the low phase.
              state_q     <= ST_SHIFT_LO;
              bit_idx_q   <= bit_idx_d;
              ccff_head_q <= shreg_q[bit_idx_d];
            end
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready      = s_ready_q;
  assign ccff_head    = ccff_head_q;
  assign prog_clk     = prog_clk_q;
  assign fabric_reset = fabric_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign bit_count    = bit_count_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb/tb_fpga_cfg_loader.sv - scoreboard bench for fpga_cfg_loader with a bit-stream reference model

module tb_fpga_cfg_loader;

  localparam int CHAIN_LEN = 20;
  localparam int DATA_W    = 8;
  localparam int PROG_DIV  = 2;
  localparam int TIMEOUT   = 10;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int NWORDS    = (CHAIN_LEN + DATA_W - 1) / DATA_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_valid = 1'b0;
  logic              ccff_tail = 1'b0;
  logic              s_ready;
  logic              ccff_head;
  logic              prog_clk;
  logic              fabric_reset;
  logic              busy;
  logic              done;
  logic              error;
  logic [CNT_W-1:0]  bit_count;
`ifdef FPGA_CFG_LOADER_READBACK_EN
  logic [7:0]        readback_crc;
`endif

  fpga_cfg_loader #(
    .CHAIN_LEN(CHAIN_LEN),
    .DATA_W   (DATA_W),
    .PROG_DIV (PROG_DIV),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .ccff_head   (ccff_head),
    .prog_clk    (prog_clk),
    .ccff_tail   (ccff_tail),
    .fabric_reset(fabric_reset),
    .busy        (busy),
    .done        (done),
    .error       (error),
`ifdef FPGA_CFG_LOADER_READBACK_EN
    .readback_crc(readback_crc),
`endif
    .bit_count   (bit_count)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   passed = 0;
  bit   exp_q[$];
  bit   tail_q[$];
  int   rises = 0;
  int   pushed = 0;
  int   hi_cnt = 0;
  logic prev_pclk = 1'b0;
  logic head_at_rise = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  // CRC-8 (poly 0x107, init 0) by polynomial long division of the bit message.
  function automatic logic [7:0] crc_model();
    logic [63:0] m = '0;
    int n = tail_q.size();
    for (int i = 0; i < n; i++) m = (m << 1) | 64'(tail_q[i]);
    m = m << 8;
    for (int i = n + 7; i >= 8; i--)
      if (m[i]) m = m ^ (64'h107 << (i - 8));
    return m[7:0];
  endfunction

  // Monitor: on every prog_clk rise, pop the next expected bit and compare.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_pclk = 1'b0;
      hi_cnt    = 0;
    end else begin
      if (prog_clk && !prev_pclk) begin
        chk("bit_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          bit e;
          e = exp_q.pop_front();
          chk("ccff_head_bit", ccff_head, e);
        end
        rises++;
        chk("bit_count_at_rise", bit_count, rises);
        tail_q.push_back(ccff_tail);
        head_at_rise = ccff_head;
        hi_cnt = 1;
      end else if (prog_clk) begin
        hi_cnt++;
        chk("head_stable_while_high", ccff_head, head_at_rise);
      end else if (prev_pclk) begin
        chk("prog_clk_high_len", hi_cnt, PROG_DIV);
      end
      prev_pclk = prog_clk;
      ccff_tail = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit with_valid);
    start = 1'b1;
    if (with_valid) begin
      s_valid = 1'b1;
      s_data  = DATA_W'($urandom);
    end
    tick();
    start   = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w);
    for (int b = DATA_W - 1; b >= 0 && pushed < CHAIN_LEN; b--) begin
      exp_q.push_back(w[b]);
      pushed++;
    end
    repeat ($urandom_range(0, 3)) tick();
    s_data  = w;
    s_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (s_ready) break;
    end
    chk("handshake_ready", s_ready, 1);
    tick();
    s_valid = 1'b0;
    s_data  = DATA_W'($urandom);
  endtask

  task automatic run_session(input bit mid_start);
    logic prev_fr;
    rises  = 0;
    pushed = 0;
    exp_q.delete();
    tail_q.delete();
    pulse_start(1'b1);
    chk("busy_after_start", busy, 1);
    chk("fabric_reset_after_start", fabric_reset, 1);
    chk("done_cleared", done, 0);
    chk("error_cleared", error, 0);
    chk("bit_count_cleared", bit_count, 0);
    for (int k = 0; k < NWORDS; k++) begin
      send_word(DATA_W'($urandom));
      if (mid_start && k == 0) begin
        repeat (5) tick();
        pulse_start(1'b0);
        chk("busy_ignores_start", busy, 1);
      end
    end
    prev_fr = fabric_reset;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (done) break;
      prev_fr = fabric_reset;
    end
    chk("done_rose", done, 1);
    chk("fabric_reset_high_before_done", prev_fr, 1);
    chk("fabric_reset_low_with_done", fabric_reset, 0);
    chk("busy_low_at_done", busy, 0);
    chk("bit_count_final", bit_count, CHAIN_LEN);
    chk("rises_total", rises, CHAIN_LEN);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("prog_clk_low_at_done", prog_clk, 0);
`ifdef FPGA_CFG_LOADER_READBACK_EN
    chk("readback_crc", readback_crc, crc_model());
`endif
    s_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_accept_after_done", s_ready, 0);
    end
    s_valid = 1'b0;
    tick();
  endtask

  task automatic timeout_test();
    pulse_start(1'b0);
    repeat (TIMEOUT) @(negedge clk);
    chk("no_error_before_timeout", error, 0);
    chk("ready_while_waiting", s_ready, 1);
    @(negedge clk);
    chk("error_at_timeout", error, 1);
    chk("fabric_reset_held_on_error", fabric_reset, 1);
    chk("busy_low_on_error", busy, 0);
    chk("ready_low_on_error", s_ready, 0);
    tick();
  endtask

  task automatic reset_test();
    rises  = 0;
    pushed = 0;
    exp_q.delete();
    tail_q.delete();
    pulse_start(1'b0);
    send_word(DATA_W'($urandom));
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (rises >= 5) break;
    end
    chk("reached_five_bits", rises >= 5, 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_prog_clk", prog_clk, 0);
    chk("rst_bit_count", bit_count, 0);
    chk("rst_fabric_reset", fabric_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_ccff_head", ccff_head, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    s_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_no_ready", s_ready, 0);
    end
    s_valid = 1'b0;
    tick();
  endtask

  initial begin
    #1;
    reset_n = 1'b0;
    #1;
    chk("init_s_ready", s_ready, 0);
    chk("init_ccff_head", ccff_head, 0);
    chk("init_prog_clk", prog_clk, 0);
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_error", error, 0);
    chk("init_bit_count", bit_count, 0);
    chk("init_fabric_reset", fabric_reset, 1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    run_session(1'b0);
    run_session(1'b1);
    timeout_test();
    run_session(1'b0);
    reset_test();
    run_session(1'b0);
    run_session(1'b1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

endmodule
